// File: rtl/dcdc_mpc_pkg.sv
// Shared types and constants for the DC-DC MPC control-cycle scheduler.
package dcdc_mpc_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int OVR_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DEAD  = 2'd2,
      ST_FAULT = 2'd3
   } sched_state_t;

   // Saturating increment for the missed-tick counter.
   function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
      return (v == '1) ? v : v + OVR_W'(1);
   endfunction

endpackage

// File: rtl/mpc_period_timer.sv
// Free-running control-period counter; produces a one-clock tick at the end of each period.
module mpc_period_timer #(
   parameter int PERIOD = 4096
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_enable,
   output logic tick
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (!i_enable) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST) & i_enable;

endmodule

// File: rtl/mpc_cycle_scheduler.sv
// Sequences one MPC control cycle per PERIOD clocks: snapshot, solver handshake,
// dead-time-protected switch drive, solver-timeout fault and overrun counting.
module mpc_cycle_scheduler
   import dcdc_mpc_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int PERIOD   = 4096,
   parameter int TIMEOUT  = 2048,
   parameter int DEADTIME = 8
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic [DATA_W-1:0] i_Vpv,
   input  logic [DATA_W-1:0] i_Ipv,
   input  logic [DATA_W-1:0] i_Vout,
   output logic [DATA_W-1:0] o_Vpv_s,
   output logic [DATA_W-1:0] o_Ipv_s,
   output logic [DATA_W-1:0] o_Vout_s,
   output logic              o_mpc_start,
   input  logic              i_mpc_done,
   input  logic              i_mpc_switch,
   output logic              o_MPC_switch,
   output logic              o_busy,
   output logic              o_fault,
   input  logic              i_fault_clr,
   output logic [OVR_W-1:0]  o_overrun_cnt
);

   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DCNT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   sched_state_t      state;
   logic [WCNT_W-1:0] wcnt;
   logic [DCNT_W-1:0] dcnt;
   logic              tick;

   mpc_period_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_enable  (i_enable),
      .tick      (tick)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         // NOTE: snapshots are plain registers, so they are reset with the rest of the state.
         state         <= ST_IDLE;
         wcnt          <= '0;
         dcnt          <= '0;
         o_Vpv_s       <= '0;
         o_Ipv_s       <= '0;
         o_Vout_s      <= '0;
         o_mpc_start   <= 1'b0;
         o_MPC_switch  <= 1'b0;
         o_busy        <= 1'b0;
         o_fault       <= 1'b0;
         o_overrun_cnt <= '0;
      end else begin
         // NOTE: start is a one-clock pulse; the default here is overridden only on an accepted tick.
         o_mpc_start <= 1'b0;

         // A tick landing while a cycle is still in flight is dropped and counted.
         if (tick && (state == ST_WAIT || state == ST_DEAD))
            o_overrun_cnt <= sat_inc(o_overrun_cnt);

         if (!i_enable) begin
            o_MPC_switch <= 1'b0;
            if (state == ST_FAULT) begin
               if (i_fault_clr) begin
                  state   <= ST_IDLE;
                  o_fault <= 1'b0;
               end
            end else begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (tick) begin
                     o_Vpv_s     <= i_Vpv;
                     o_Ipv_s     <= i_Ipv;
                     o_Vout_s    <= i_Vout;
                     o_mpc_start <= 1'b1;
                     wcnt        <= '0;
                     o_busy      <= 1'b1;
                     state       <= ST_WAIT;
                  end
               end

               ST_WAIT: begin
                  // Done has priority over a coincident timeout.
                  if (i_mpc_done) begin
                     if (i_mpc_switch && !o_MPC_switch && (DEADTIME > 0)) begin
                        dcnt  <= DCNT_W'(DEADTIME);
                        state <= ST_DEAD;
                     end else begin
                        o_MPC_switch <= i_mpc_switch;
                        o_busy       <= 1'b0;
                        state        <= ST_IDLE;
                     end
                  end else if (wcnt == WCNT_LAST) begin
                     o_MPC_switch <= 1'b0;
                     o_fault      <= 1'b1;
                     o_busy       <= 1'b0;
                     state        <= ST_FAULT;
                  end else begin
                     wcnt <= wcnt + WCNT_W'(1);
                  end
               end

               ST_DEAD: begin
                  if (dcnt == DCNT_W'(1)) begin
                     o_MPC_switch <= 1'b1;
                     o_busy       <= 1'b0;
                     state        <= ST_IDLE;
                  end else begin
                     o_MPC_switch <= 1'b0;
                     dcnt         <= dcnt - DCNT_W'(1);
                  end
               end

               ST_FAULT: begin
                  o_MPC_switch <= 1'b0;
                  if (i_fault_clr) begin
                     o_fault <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mpc_cycle_scheduler.sv
// Directed bench for mpc_cycle_scheduler (PERIOD=16, DEADTIME=2; TIMEOUT 8 and 20 instances).
module tb_mpc_cycle_scheduler;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] vpv = '0, ipv = '0, vout = '0;
   logic          done = 1'b0, done2 = 1'b0, sw = 1'b0, clr = 1'b0;

   logic [DW-1:0] vpv_s, ipv_s, vout_s, ov_vpv_s, ov_ipv_s, ov_vout_s;
   logic          start, msw, busy, fault;
   logic          ov_start, ov_msw, ov_busy, ov_fault;
   logic [15:0]   ovr, ov_ovr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mpc_cycle_scheduler #(.DATA_W(DW), .PERIOD(16), .TIMEOUT(8), .DEADTIME(2)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
      .i_Vpv(vpv), .i_Ipv(ipv), .i_Vout(vout),
      .o_Vpv_s(vpv_s), .o_Ipv_s(ipv_s), .o_Vout_s(vout_s),
      .o_mpc_start(start), .i_mpc_done(done), .i_mpc_switch(sw),
      .o_MPC_switch(msw), .o_busy(busy), .o_fault(fault),
      .i_fault_clr(clr), .o_overrun_cnt(ovr)
   );

   mpc_cycle_scheduler #(.DATA_W(DW), .PERIOD(16), .TIMEOUT(20), .DEADTIME(2)) dut_ov (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
      .i_Vpv(vpv), .i_Ipv(ipv), .i_Vout(vout),
      .o_Vpv_s(ov_vpv_s), .o_Ipv_s(ov_ipv_s), .o_Vout_s(ov_vout_s),
      .o_mpc_start(ov_start), .i_mpc_done(done2), .i_mpc_switch(sw),
      .o_MPC_switch(ov_msw), .o_busy(ov_busy), .o_fault(ov_fault),
      .i_fault_clr(clr), .o_overrun_cnt(ov_ovr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until the selected instance raises start; returns the clock count via a check.
   task automatic wait_start(input bit sel, input int exp_n, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(sel ? ov_start : start) && n < 64);
      check(tag, n, exp_n);
   endtask

   task automatic pulse_done(input logic s);
      done = 1'b1;
      sw   = s;
      step();
      done = 1'b0;
   endtask

   initial begin
      bit seen;

      // Reset and idle state
      step();
      rst_n = 1'b1;
      step();
      step();
      check("rst_start", start, 0);
      check("rst_switch", msw, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault, 0);
      check("rst_ovr", ovr, 0);
      check("rst_vpv_s", vpv_s, 0);

      // First cycle: snapshot and start timing
      vpv = 100; ipv = 5; vout = 48;
      enable = 1'b1;
      wait_start(0, 16, "start_latency");
      check("snap_vpv", vpv_s, 100);
      check("snap_ipv", ipv_s, 5);
      check("snap_vout", vout_s, 48);
      vpv = 999; ipv = 7; vout = 9;
      step();
      check("start_one_cycle", start, 0);
      check("busy_wait", busy, 1);
      check("snap_stable", vpv_s, 100);
      step();

      // Turn-on through dead time
      pulse_done(1);
      check("dead_sw0", msw, 0);
      check("dead_busy", busy, 1);
      step();
      check("dead_sw1", msw, 0);
      step();
      check("sw_on", msw, 1);
      check("sw_on_busy", busy, 0);

      // Turn-off, no dead time
      wait_start(0, 11, "start_period2");
      check("sw_held", msw, 1);
      pulse_done(0);
      check("sw_off", msw, 0);
      check("off_busy", busy, 0);

      // Solver timeout
      wait_start(0, 15, "start_period3");
      repeat (7) step();
      check("pre_timeout_fault", fault, 0);
      check("pre_timeout_busy", busy, 1);
      step();
      check("timeout_fault", fault, 1);
      check("timeout_sw", msw, 0);
      check("timeout_busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (start) seen = 1'b1;
      end
      check("fault_no_start", seen, 0);
      check("fault_no_overrun", ovr, 0);
      check("fault_held", fault, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("fault_cleared", fault, 0);
      wait_start(0, 13, "start_after_clr");
      pulse_done(0);

      // Overrun on the TIMEOUT=20 instance
      vpv = 200;
      rst_n = 1'b0;
      #1;
      check("async_rst_fault", fault, 0);
      step();
      rst_n = 1'b1;
      wait_start(1, 16, "ov_start");
      check("ov_snap", ov_vpv_s, 200);
      vpv = 300;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (ov_start) seen = 1'b1;
      end
      check("ov_cnt_before", ov_ovr, 0);
      step();
      if (ov_start) seen = 1'b1;
      check("ov_cnt_after", ov_ovr, 1);
      check("ov_no_extra_start", seen, 0);
      check("ov_snap_kept", ov_vpv_s, 200);
      check("ov_busy", ov_busy, 1);
      done2 = 1'b1;
      sw    = 1'b0;
      step();
      done2 = 1'b0;
      check("ov_done_idle", ov_busy, 0);
      check("ov_cnt_kept", ov_ovr, 1);

      // Drop enable while in dead time
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr2_fault", fault, 0);
      wait_start(0, 14, "start_before_dead");
      pulse_done(1);
      check("in_dead_busy", busy, 1);
      enable = 1'b0;
      step();
      check("dis_sw", msw, 0);
      check("dis_busy", busy, 0);
      step();
      check("dis_sw_later", msw, 0);
      pulse_done(1);
      check("late_done_sw", msw, 0);
      check("late_done_busy", busy, 0);
      enable = 1'b1;
      wait_start(0, 16, "restart_latency");

      // Asynchronous reset during the start pulse
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_start", start, 0);
      check("arst_snap", vpv_s, 0);
      check("arst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
